// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch sequencer and its return-address stack.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pc_seq_pkg;

    // FSM encoding is visible on the state output, so the values are fixed.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        HALT  = 3'd3
    } state_e;

    // Return-address stack depth; must stay a power of two so the pointer wraps naturally.
    localparam int RAS_DEPTH = 4;

    localparam int DEF_PC_W      = 8;
    localparam int DEF_STEP      = 4;
    localparam int DEF_BOOT_ADDR = 0;

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty yields BOOT_ADDR.
// Latency: pop_dat_o is the current top (combinational from registers); push/pop take effect next edge.
// Backpressure: none; over/underflow is absorbed and recorded in the sticky err_o flag.
module pc_seq_ras
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter logic [PC_W-1:0] BOOT_ADDR = PC_W'(DEF_BOOT_ADDR)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_dat_i,
    output logic [PC_W-1:0] pop_dat_o,
    output logic            err_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;   // next slot to write; top of stack sits just below it
    logic [PTR_W:0]   cnt_q;      // live entries, saturates at RAS_DEPTH
    logic             err_q;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] top_ptr;

    assign full      = (cnt_q == (PTR_W+1)'(RAS_DEPTH));
    assign empty     = (cnt_q == '0);
    assign top_ptr   = wr_ptr_q - 1'b1;
    assign pop_dat_o = empty ? BOOT_ADDR : mem_q[top_ptr];
    assign err_o     = err_q;

    // Stack storage and pointers; a push when full lands on the oldest slot because the pointer wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
            if (full) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (pop_i) begin
            if (empty) begin
                err_q <= 1'b1;
            end else begin
                wr_ptr_q <= wr_ptr_q - 1'b1;
                cnt_q    <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the PC: fetches one byte per instruction over req/ack and hands it to decode over valid/ready; optional RAS under PC_SEQ_RAS_EN.
// Latency: start -> req next cycle; ack -> instr_valid next cycle; handshake -> new pc next cycle (peak 1 instr / 2 cycles).
// Backpressure: waits indefinitely for imem_ack and instr_ready; ena low freezes sequencing but never drops a pending req or valid.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter int              STEP      = DEF_STEP,
    parameter logic [PC_W-1:0] BOOT_ADDR = PC_W'(DEF_BOOT_ADDR)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            start,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic            instr_valid,
    output logic [7:0]      instr,
    input  logic            instr_ready,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            call_valid,
    input  logic            ret_valid,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      state,
    output logic            ras_err
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      instr_q, instr_d;
    logic            req_q;
    logic            valid_q;
    logic            issue_hs;
    logic [PC_W-1:0] pc_inc;

    // The handshake is the single point where the PC moves and the control inputs are looked at.
    assign issue_hs = (state_q == ISSUE) && valid_q && instr_ready;
    assign pc_inc   = pc_q + PC_W'(STEP);   // silent wrap at 2^PC_W

`ifdef PC_SEQ_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;

    assign ras_pop  = issue_hs && ret_valid;
    assign ras_push = issue_hs && call_valid && !ret_valid;

    pc_seq_ras #(
        .PC_W      (PC_W),
        .BOOT_ADDR (BOOT_ADDR)
    ) u_ras (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (ras_push),
        .pop_i      (ras_pop),
        .push_dat_i (pc_inc),
        .pop_dat_o  (ras_top),
        .err_o      (ras_err)
    );
`else
    logic unused_ras_ctl;
    assign unused_ras_ctl = call_valid ^ ret_valid;
    assign ras_err        = 1'b0;
`endif

    // Next PC at the issue handshake: ret > call > branch > increment.
    always_comb begin
        pc_d = pc_q;
        if (issue_hs) begin
            pc_d = br_valid ? br_target : pc_inc;
`ifdef PC_SEQ_RAS_EN
            if (ret_valid) begin
                pc_d = ras_top;
            end else if (call_valid) begin
                pc_d = br_target;
            end
`endif
        end
    end

    // Sequencing FSM: ena only gates leaving IDLE/HALT; an ack in flight is always taken.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE, HALT: begin
                if (start && ena) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_hs) begin
                    state_d = halt_req ? HALT : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and registered handshake outputs; req/valid are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= BOOT_ADDR;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= (state_d == FETCH);
            valid_q <= (state_d == ISSUE);
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus random traffic against a transaction-level model.
// Stimulus is driven 1 time unit after each rising edge; the monitor checks on the falling edge.
// Expected fetched bytes are queued when the memory acks and popped when decode accepts.
module tb_pc_fetch_sequencer;

    localparam int ST_IDLE  = 0;
    localparam int ST_FETCH = 1;
    localparam int ST_ISSUE = 2;
    localparam int ST_HALT  = 3;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena, start, halt_req;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       br_valid;
    logic [7:0] br_target;
    logic       call_valid, ret_valid;
    logic [7:0] pc;
    logic [2:0] state;
    logic       ras_err;

    pc_fetch_sequencer #(.PC_W(8), .STEP(4), .BOOT_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .br_valid(br_valid), .br_target(br_target), .call_valid(call_valid), .ret_valid(ret_valid),
        .pc(pc), .state(state), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         errors;
    logic [7:0] mem [256];
    int         exp_state;
    logic [7:0] exp_pc;
    bit         exp_err;
    logic [7:0] exp_instr_q [$];
    logic [7:0] ras_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_state = ST_IDLE;
        exp_pc    = 8'h00;
        exp_err   = 1'b0;
        exp_instr_q.delete();
        ras_q.delete();
    endtask

    // Where the PC goes after an accepted instruction, from the control inputs of that cycle.
    task automatic model_redirect();
        logic [7:0] seq;
        seq = exp_pc + 8'd4;
        if (RAS_EN && ret_valid) begin
            if (ras_q.size() == 0) begin
                exp_pc  = 8'h00;
                exp_err = 1'b1;
            end else begin
                exp_pc = ras_q.pop_back();
            end
        end else if (RAS_EN && call_valid) begin
            if (ras_q.size() == 4) begin
                void'(ras_q.pop_front());
                exp_err = 1'b1;
            end
            ras_q.push_back(seq);
            exp_pc = br_target;
        end else if (br_valid) begin
            exp_pc = br_target;
        end else begin
            exp_pc = seq;
        end
    endtask

    // Monitor: compare visible outputs with the model, then advance the model by one cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("state", 32'(state), 32'(exp_state));
            chk("pc", 32'(pc), 32'(exp_pc));
            chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
            chk("imem_req", 32'(imem_req), 32'(exp_state == ST_FETCH));
            chk("instr_valid", 32'(instr_valid), 32'(exp_state == ST_ISSUE));
            chk("ras_err", 32'(ras_err), 32'(exp_err));
            if (exp_state == ST_ISSUE) begin
                if (exp_instr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL instr_queue: got empty scoreboard, expected one pending byte");
                end else begin
                    chk("instr", 32'(instr), 32'(exp_instr_q[0]));
                end
            end
            case (exp_state)
                ST_IDLE, ST_HALT: if (start && ena) exp_state = ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        exp_instr_q.push_back(mem[exp_pc]);
                        exp_state = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        void'(exp_instr_q.pop_front());
                        model_redirect();
                        exp_state = halt_req ? ST_HALT : ST_FETCH;
                    end
                end
                default: exp_state = ST_IDLE;
            endcase
        end
    end

    // One cycle of stimulus; the memory only acks when it sees a request.
    task automatic drive(input bit ack, input bit rdy, input bit st, input bit en, input bit hr,
                         input bit br, input logic [7:0] tgt, input bit cl, input bit rt);
        imem_ack    = ack & imem_req;
        imem_rdata  = mem[imem_addr];
        instr_ready = rdy;
        start       = st;
        ena         = en;
        halt_req    = hr;
        br_valid    = br;
        br_target   = tgt;
        call_valid  = cl;
        ret_valid   = rt;
        @(posedge clk);
        #1;
    endtask

    // Run until an instruction is offered, then accept it with the given controls.
    task automatic issue(input bit br, input logic [7:0] tgt, input bit hr, input bit cl, input bit rt);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            drive(1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
            n++;
        end
        if (!instr_valid) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no instr_valid in 20 cycles, expected one");
        end
        drive(1, 1, 0, 1, hr, br, tgt, cl, rt);
    endtask

    initial begin
        int n;
        bit en;
        checks = 0;
        errors = 0;
        foreach (mem[i]) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        ena = 0; start = 0; halt_req = 0; imem_ack = 0; imem_rdata = 0;
        instr_ready = 0; br_valid = 0; br_target = 0; call_valid = 0; ret_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_state", 32'(state), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_ras_err", 32'(ras_err), 0);

        // Zero-wait streaming: fetches 0x00, 0x04, 0x08 then sits in FETCH at 0x0C.
        drive(0, 0, 1, 1, 0, 0, 8'h00, 0, 0);
        repeat (6) drive(1, 1, 0, 1, 0, 0, 8'h00, 0, 0);
        chk("seq_pc", 32'(pc), 32'h0C);
        chk("seq_state", 32'(state), ST_FETCH);

        // Wrap: branch to 0xFC, then plain increment lands on 0x00.
        issue(1, 8'hFC, 0, 0, 0);
        chk("br_fc_pc", 32'(pc), 32'hFC);
        issue(0, 8'h00, 0, 0, 0);
        chk("wrap_pc", 32'(pc), 32'h00);

        // Stall in FETCH with ena low, then an ack that arrives while ena is low again.
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        chk("stall_req", 32'(imem_req), 1);
        chk("stall_addr", 32'(imem_addr), 32'h00);
        drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        chk("stall_ack_state", 32'(state), ST_ISSUE);
        chk("stall_ack_instr", 32'(instr), 32'(mem[0]));
        issue(0, 8'h00, 0, 0, 0);

        // Branch and halt together, idle a while, then resume from the branch target.
        issue(1, 8'h40, 1, 0, 0);
        chk("halt_state", 32'(state), ST_HALT);
        chk("halt_pc", 32'(pc), 32'h40);
        repeat (3) drive(1, 1, 0, 1, 0, 0, 8'h00, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 8'h00, 0, 0);
        chk("resume_req", 32'(imem_req), 1);
        chk("resume_addr", 32'(imem_addr), 32'h40);

        // Call/return sequence (ignored controls without the stack build).
        issue(1, 8'h10, 0, 0, 0);
        issue(0, 8'h80, 0, 1, 0);
        issue(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 5; i++) issue(0, 8'(8'h80 + 8 * i), 0, 1, 0);
        for (int i = 0; i < 6; i++) issue(0, 8'h00, 0, 0, 1);

        // Random traffic; decode never accepts while ena is low.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 9) < 6, ($urandom_range(0, 9) < 7) && en, $urandom_range(0, 3) == 0,
                  en, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, 8'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset while an instruction is being offered.
        n = 0;
        while (!instr_valid && n < 30) begin
            drive(1, 0, 1, 1, 0, 0, 8'h00, 0, 0);
            n++;
        end
        chk("pre_reset_valid", 32'(instr_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_req", 32'(imem_req), 0);
        chk("arst_pc", 32'(pc), 0);
        chk("arst_state", 32'(state), ST_IDLE);
        chk("arst_instr", 32'(instr), 0);
        chk("arst_ras_err", 32'(ras_err), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 1, 1, 0, 0, 8'h00, 0, 0);
        repeat (10) drive(1, 1, 0, 1, 0, 0, 8'h00, 0, 0);
        chk("post_reset_pc", 32'(pc), 32'h14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
